// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch sequencer feeding uart_tx: buffers producer bytes and issues one
// start pulse per byte, pacing on the transmitter's busy flag and flagging a missing busy.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_flush,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_start,
  input  logic                     i_tx_busy,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ARM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_SEND = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            err_q, err_d;
  logic            err_set_s;
  logic            wr_en_s;
  logic            launch_s;
  logic [7:0]      mem_q [DEPTH];

  // Ready looks only at the registered count, so a same-cycle pop never frees a full FIFO.
  assign o_ready    = !rst && (count_q != CW'(DEPTH)) && !i_flush;
  assign o_empty    = (count_q == CW'(0));
  assign o_count    = count_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_err      = err_q;

  assign wr_en_s  = i_valid && o_ready;
  assign launch_s = (state_q == S_IDLE) && (count_q != CW'(0)) && !i_tx_busy && !i_flush;

  // FIFO pointer and occupancy update; flush overrides any write or launch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = CW'(0);
    end else begin
      wr_ptr_d = wr_en_s  ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = launch_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      case ({wr_en_s, launch_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Launch sequencer; ARM/SEND keep running through a flush so the in-flight byte finishes.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_set_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch_s) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          timer_d    = TW'(0);
          state_d    = S_ARM;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_ARM: begin
        if (i_tx_busy) begin
          state_d = S_SEND;
        end else if (timer_q == TW'(ARM_TIMEOUT - 1)) begin
          err_set_s = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d   = timer_q + TW'(1);
        end
      end
      S_SEND: begin
        if (!i_tx_busy) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = i_flush ? 1'b0 : (err_set_s ? 1'b1 : err_q);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= AW'(0);
      rd_ptr_q   <= AW'(0);
      count_q    <= CW'(0);
      timer_q    <= TW'(0);
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
    end
  end

  // Storage array; contents are don't-care until counted, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a behavioural busy model stands in for uart_tx and a
// byte scoreboard checks launch order, occupancy, flush, error timeout and reset behaviour.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int FRAME = 40;

  logic          clk;
  logic          rst;
  logic [7:0]    i_data;
  logic          i_valid;
  logic          o_ready;
  logic          i_flush;
  logic [7:0]    o_tx_data;
  logic          o_tx_start;
  logic          tx_busy;
  logic [CW-1:0] o_count;
  logic          o_empty;
  logic          o_err;

  logic          uart_en;
  logic          hold_busy;
  int            busy_cnt;
  int            frames_done;
  int            start_cnt;
  logic          prev_busy;
  logic [7:0]    exp_q [$];
  int            n_tests;
  int            n_fail;

  uart_tx_fifo #(.DEPTH(DEPTH), .ARM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_flush    (i_flush),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_busy  (tx_busy),
    .o_count    (o_count),
    .o_empty    (o_empty),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_busy = uart_en ? (busy_cnt != 0) : hold_busy;

  // Transmitter stand-in: busy rises the edge after it samples a start pulse, lasts FRAME cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt    <= 0;
      frames_done <= 0;
    end else if (uart_en && o_tx_start && busy_cnt == 0) begin
      busy_cnt <= FRAME;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) frames_done <= frames_done + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: pop on each start pulse, compare occupancy, then apply the upcoming edge's flush/write.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_busy <= 1'b0;
      start_cnt <= 0;
    end else begin
      if (o_tx_start) begin
        start_cnt <= start_cnt + 1;
        check("start_while_busy", {31'd0, prev_busy}, 32'd0);
        if (exp_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
        else check("tx_data", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
      end
      check("count", {27'd0, o_count}, exp_q.size());
      check("empty", {31'd0, o_empty}, {31'd0, exp_q.size() == 0});
      if (i_flush) exp_q.delete();
      else if (i_valid && o_ready) exp_q.push_back(i_data);
      prev_busy <= tx_busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_rdy);
    i_valid = 1'b1;
    i_data  = d;
    @(negedge clk);
    check("ready_on_write", {31'd0, o_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int quiet;
    quiet = 0;
    for (int i = 0; i < max_cycles && quiet < 4; i++) begin
      @(posedge clk);
      #1;
      if (o_empty && !tx_busy && !o_tx_start) quiet++;
      else quiet = 0;
    end
    check("idle_timeout", {31'd0, quiet >= 4}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int f0;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    i_data    = 8'h00;
    i_valid   = 1'b0;
    i_flush   = 1'b0;
    uart_en   = 1'b1;
    hold_busy = 1'b0;

    // reset values
    tick(3);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_empty", {31'd0, o_empty}, 32'd1);
    check("rst_count", {27'd0, o_count}, 32'd0);
    check("rst_start", {31'd0, o_tx_start}, 32'd0);
    check("rst_data", {24'd0, o_tx_data}, 32'h00);
    check("rst_err", {31'd0, o_err}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, o_ready}, 32'd1);

    // single byte, two-edge launch latency
    write_byte(8'hA5, 1'b1);
    check("t1_count", {27'd0, o_count}, 32'd1);
    check("t1_no_start_yet", {31'd0, o_tx_start}, 32'd0);
    tick(1);
    check("t1_start", {31'd0, o_tx_start}, 32'd1);
    check("t1_data", {24'd0, o_tx_data}, 32'hA5);
    check("t1_empty", {31'd0, o_empty}, 32'd1);
    tick(1);
    check("t1_pulse_width", {31'd0, o_tx_start}, 32'd0);
    wait_idle(300);
    check("t1_data_held", {24'd0, o_tx_data}, 32'hA5);

    // back-to-back burst: 17 accepted (one launched), then full
    for (int i = 0; i < 17; i++) write_byte(8'(i), 1'b1);
    check("t2_count_full", {27'd0, o_count}, DEPTH);
    @(negedge clk);
    check("t2_ready_full", {31'd0, o_ready}, 32'd0);
    @(posedge clk);
    #1;
    wait_idle(1500);

    // full FIFO: write refused while a pop happens the same edge
    uart_en   = 1'b0;
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_byte(8'h40 + 8'(i), 1'b1);
    check("t3_count_full", {27'd0, o_count}, DEPTH);
    i_valid   = 1'b1;
    i_data    = 8'hEE;
    hold_busy = 1'b0;
    @(negedge clk);
    check("t3_ready_full", {31'd0, o_ready}, 32'd0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("t3_count_after_pop", {27'd0, o_count}, DEPTH - 1);
    check("t3_start", {31'd0, o_tx_start}, 32'd1);
    check("t3_data", {24'd0, o_tx_data}, 32'h40);
    uart_en = 1'b1;
    wait_idle(1500);

    // busy never rises: sticky error after four ARM cycles, cleared by flush
    uart_en   = 1'b0;
    hold_busy = 1'b0;
    write_byte(8'h3C, 1'b1);
    tick(1);
    check("t4_start", {31'd0, o_tx_start}, 32'd1);
    check("t4_data", {24'd0, o_tx_data}, 32'h3C);
    tick(3);
    check("t4_err_early", {31'd0, o_err}, 32'd0);
    tick(1);
    check("t4_err_set", {31'd0, o_err}, 32'd1);
    tick(3);
    check("t4_err_sticky", {31'd0, o_err}, 32'd1);
    check("t4_no_relaunch", {31'd0, o_tx_start}, 32'd0);
    i_flush = 1'b1;
    @(negedge clk);
    check("t4_ready_flush", {31'd0, o_ready}, 32'd0);
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    check("t4_err_cleared", {31'd0, o_err}, 32'd0);

    // flush during SEND: in-flight byte finishes, queued bytes discarded
    uart_en = 1'b1;
    tick(1);
    s0 = start_cnt;
    f0 = frames_done;
    for (int i = 0; i < 5; i++) write_byte(8'h51 + 8'(i), 1'b1);
    for (int i = 0; i < 20 && !tx_busy; i++) tick(1);
    check("t5_busy", {31'd0, tx_busy}, 32'd1);
    i_flush = 1'b1;
    tick(1);
    i_flush = 1'b0;
    check("t5_count", {27'd0, o_count}, 32'd0);
    check("t5_empty", {31'd0, o_empty}, 32'd1);
    wait_idle(300);
    tick(2 * FRAME);
    check("t5_starts", start_cnt - s0, 32'd1);
    check("t5_frames", frames_done - f0, 32'd1);

    // asynchronous reset mid-frame with three bytes queued
    for (int i = 0; i < 4; i++) write_byte(8'h61 + 8'(i), 1'b1);
    for (int i = 0; i < 20 && !tx_busy; i++) tick(1);
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    check("t6_start", {31'd0, o_tx_start}, 32'd0);
    check("t6_data", {24'd0, o_tx_data}, 32'h00);
    check("t6_count", {27'd0, o_count}, 32'd0);
    check("t6_empty", {31'd0, o_empty}, 32'd1);
    check("t6_ready", {31'd0, o_ready}, 32'd0);
    check("t6_err", {31'd0, o_err}, 32'd0);
    tick(2);
    rst = 1'b0;
    #1;
    check("t6_ready_release", {31'd0, o_ready}, 32'd1);
    s0 = start_cnt;
    tick(100);
    check("t6_no_start", start_cnt - s0, 32'd0);
    write_byte(8'h77, 1'b1);
    wait_idle(300);
    check("t6_new_start", start_cnt - s0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
